// File: rtl/sharp_ctrl_pkg.sv
// Shared types and widths for the sharpening raster-scan sequencer.
package sharp_ctrl_pkg;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 5;
    localparam int LEAD_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // True when a coordinate sits on the first or last line of its axis.
    function automatic logic on_edge(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] last);
        return (v == '0) || (v == last);
    endfunction

endpackage

// File: rtl/sharp_scan_ctrl_if.sv
// Command and memory handshake bundle between the scan sequencer and its host/memory side.
// The ABORT line exists only when SHARP_SCAN_ABORT_EN is defined.
interface sharp_scan_ctrl_if;
    import sharp_ctrl_pkg::ADDR_W;

    logic              START;
    logic              BUSY;
    logic              DONE;
    logic              RD_REQ;
    logic              RD_ACK;
    logic [ADDR_W-1:0] RD_ADDR;
    logic              WR_REQ;
    logic              WR_ACK;
    logic [ADDR_W-1:0] WR_ADDR;
    logic              WR_BORDER;

`ifdef SHARP_SCAN_ABORT_EN
    logic              ABORT;

    modport master (
        input  START, RD_ACK, WR_ACK, ABORT,
        output BUSY, DONE, RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_BORDER
    );

    modport slave (
        output START, RD_ACK, WR_ACK, ABORT,
        input  BUSY, DONE, RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_BORDER
    );
`else
    modport master (
        input  START, RD_ACK, WR_ACK,
        output BUSY, DONE, RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_BORDER
    );

    modport slave (
        output START, RD_ACK, WR_ACK,
        input  BUSY, DONE, RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_BORDER
    );
`endif

endinterface

// File: rtl/CNT5.sv
// Team 5-bit up counter: synchronous clear has priority over count enable.
module CNT5 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    output logic [4:0] CNT
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT <= 5'd0;
        end else if (CE) begin
            CNT <= CNT + 5'd1;
        end
    end

endmodule

// File: rtl/sharp_scan_ctrl_ptr.sv
// Raster pointer (column, row) built from two CNT5 counters; column wraps at LAST_COL.
module sharp_scan_ctrl_ptr
    import sharp_ctrl_pkg::*;
#(
    parameter int LAST_COL = 31
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row
);

    localparam logic [CNT_W-1:0] LAST_COL_C = CNT_W'(LAST_COL);

    logic col_wrap;
    logic col_rst;

    // Wrap is a counter clear, so it must beat the enable on the same edge.
    assign col_wrap = CE && (col == LAST_COL_C);
    assign col_rst  = RST || col_wrap;

    CNT5 u_col (
        .CLK (CLK),
        .RST (col_rst),
        .CE  (CE),
        .CNT (col)
    );

    CNT5 u_row (
        .CLK (CLK),
        .RST (RST),
        .CE  (col_wrap),
        .CNT (row)
    );

endmodule

// File: rtl/sharp_scan_ctrl.sv
// Raster-scan sequencer: reads lead writes by one line plus one pixel; flags border writes.
// Defining SHARP_SCAN_ABORT_EN adds an ABORT input that returns the scan to IDLE.
module sharp_scan_ctrl
    import sharp_ctrl_pkg::*;
#(
    parameter int LAST_COL = 31,
    parameter int LAST_ROW = 31
) (
    input logic               CLK,
    input logic               RST,
    sharp_scan_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0]  LAST_COL_C = CNT_W'(LAST_COL);
    localparam logic [CNT_W-1:0]  LAST_ROW_C = CNT_W'(LAST_ROW);
    localparam logic [LEAD_W-1:0] LEAD_MAX   = LEAD_W'(LAST_COL + 2);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  col_r;
    logic [CNT_W-1:0]  row_r;
    logic [CNT_W-1:0]  col_w;
    logic [CNT_W-1:0]  row_w;
    logic [LEAD_W-1:0] lead;
    logic [LEAD_W-1:0] lead_nxt;
    logic              rd_done;
    logic              cnt_clr;
    logic              rd_ce;
    logic              wr_ce;
    logic              rd_at_last;
    logic              wr_at_last;
    logic              abort;

`ifdef SHARP_SCAN_ABORT_EN
    assign abort = bus.ABORT;
`else
    assign abort = 1'b0;
`endif

    // A START seen in IDLE restarts every pointer; an abort deliberately leaves them alone.
    assign cnt_clr    = RST || ((state == IDLE) && bus.START);
    assign rd_ce      = (state == RD) && bus.RD_ACK;
    assign wr_ce      = (state == WR) && bus.WR_ACK;
    assign rd_at_last = (row_r == LAST_ROW_C) && (col_r == LAST_COL_C);
    assign wr_at_last = (row_w == LAST_ROW_C) && (col_w == LAST_COL_C);

    sharp_scan_ctrl_ptr #(.LAST_COL(LAST_COL)) u_rd_ptr (
        .CLK (CLK),
        .RST (cnt_clr),
        .CE  (rd_ce),
        .col (col_r),
        .row (row_r)
    );

    sharp_scan_ctrl_ptr #(.LAST_COL(LAST_COL)) u_wr_ptr (
        .CLK (CLK),
        .RST (cnt_clr),
        .CE  (wr_ce),
        .col (col_w),
        .row (row_w)
    );

    always_comb begin
        lead_nxt = lead;
        if (rd_ce && (lead < LEAD_MAX)) begin
            lead_nxt = lead + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (cnt_clr) begin
            lead    <= '0;
            rd_done <= 1'b0;
        end else begin
            lead <= lead_nxt;
            if (rd_ce && rd_at_last) begin
                rd_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions only happen on an accepted transaction, so a stalled request never moves.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                if (rd_ce && ((lead_nxt == LEAD_MAX) || rd_done || rd_at_last)) begin
                    state_nxt = WR;
                end
            end
            WR: begin
                if (wr_ce) begin
                    if (wr_at_last) begin
                        state_nxt = DONE;
                    end else if (rd_done) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    assign bus.BUSY      = (state != IDLE);
    assign bus.DONE      = (state == DONE);
    assign bus.RD_REQ    = (state == RD);
    assign bus.WR_REQ    = (state == WR);
    assign bus.RD_ADDR   = {row_r, col_r};
    assign bus.WR_ADDR   = {row_w, col_w};
    assign bus.WR_BORDER = (state == WR) &&
                           (on_edge(row_w, LAST_ROW_C) || on_edge(col_w, LAST_COL_C));

endmodule
